sklansky_seq_add: RTL and testbench

Multi-word adder sequencer built around one shared 6-bit combinational `sklansky_all` instance (ports `a`, `b`, `s`, `c6`; no carry-in). It adds two `6*WORDS`-bit operands plus a carry-in, one 6-bit word per cycle, LSW first. The adder has no carry-in, so a propagated carry is injected with a second adder pass (`+1`) on the same word. It sits between operand producers and consumers as a start/done-handshaked arithmetic unit.

---
 rtl/sklansky_seq_add.sv | 203 ++++++++++++++++++++
 tb/tb_sklansky_seq_add.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sklansky_seq_add.sv
// sklansky_seq_add: multi-word adder sequencer around one shared 6-bit
// Sklansky prefix adder. It adds two 6*WORDS-bit operands and a carry-in,
// one 6-bit word per cycle, starting with the least significant word.
// When a word is entered with a pending carry, a second pass adds 1 to the
// partial sum, because the shared adder has no carry-in.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request, sampled only while ready=1
//   a_in     operand A (W bits), latched on an accepted start
//   b_in     operand B (W bits), latched on an accepted start
//   cin      carry-in, latched on an accepted start
//   ready    high in IDLE only
//   busy     high in ADD, INC and DONE
//   done     one-cycle pulse, result valid
//   sum_out  result (W bits), held from done until the next accepted start
//   cout     carry-out, held like sum_out

// sklansky_all: 6-bit combinational Sklansky prefix adder without carry-in.
//   a, b  6-bit addends
//   s     6-bit sum
//   c6    carry out of bit 5
module sklansky_all (
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] s,
    output logic       c6
);
    // One prefix level. For each bit whose bit 'lvl' is set, merge its
    // (g,p) with the group ending just below its aligned 2^lvl block.
    function automatic logic [11:0] sk_level(input logic [5:0] g,
                                             input logic [5:0] p,
                                             input int unsigned lvl);
        logic [5:0] gn;
        logic [5:0] pn;
        int unsigned j;
        gn = g;
        pn = p;
        for (int unsigned i = 0; i < 6; i++) begin
            if (((i >> lvl) & 1) == 1) begin
                j     = ((i >> lvl) << lvl) - 1;
                gn[i] = g[i] | (p[i] & g[j]);
                pn[i] = p[i] & p[j];
            end
        end
        return {pn, gn};
    endfunction

    logic [5:0]  g0, p0;
    logic [11:0] gp1, gp2, gp3;

    assign g0  = a & b;
    assign p0  = a ^ b;
    assign gp1 = sk_level(g0, p0, 0);
    assign gp2 = sk_level(gp1[5:0], gp1[11:6], 1);
    assign gp3 = sk_level(gp2[5:0], gp2[11:6], 2);

    // gp3[5:0] holds the group generate from bit 0 to each bit.
    assign s  = p0 ^ {gp3[4:0], 1'b0};
    assign c6 = gp3[5];
endmodule

module sklansky_seq_add #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6*WORDS-1:0] a_in,
    input  logic [6*WORDS-1:0] b_in,
    input  logic              cin,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [6*WORDS-1:0] sum_out,
    output logic              cout
);
    localparam int W  = 6 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_INC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            c1_q, c1_d;
    logic            cout_q, cout_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [31:0]     woff;
    logic [5:0]      add_a, add_b, add_s;
    logic            add_c6;
    logic            last_word;

    assign woff      = 32'(idx_q) * 32'd6;
    assign last_word = (idx_q == IW'(WORDS - 1));

    // Shared adder: the INC pass adds 1 to the partial sum of the same word.
    always_comb begin
        if (state_q == S_INC) begin
            add_a = sum_q[woff +: 6];
            add_b = 6'd1;
        end else begin
            add_a = a_q[woff +: 6];
            add_b = b_q[woff +: 6];
        end
    end

    sklansky_all u_add (
        .a  (add_a),
        .b  (add_b),
        .s  (add_s),
        .c6 (add_c6)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c1_q    <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c1_q    <= c1_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c1_d    = c1_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                sum_d[woff +: 6] = add_s;
                c1_d             = add_c6;
                if (carry_q) begin
                    state_d = S_INC;
                end else begin
                    carry_d = add_c6;
                    if (last_word) begin
                        cout_d  = add_c6;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_INC: begin
                // Pass-1 carry and +1 carry are mutually exclusive (max 62+1).
                sum_d[woff +: 6] = add_s;
                carry_d          = c1_q | add_c6;
                if (last_word) begin
                    cout_d  = c1_q | add_c6;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign sum_out = sum_q;
    assign cout    = cout_q;
endmodule

// File: tb/tb_sklansky_seq_add.sv
// Self-checking bench for sklansky_seq_add: one WORDS=4 instance for the
// directed cases and one WORDS=1 instance for the exhaustive sweep.
module tb_sklansky_seq_add;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // WORDS=4 instance
    logic        start4, cin4, ready4, busy4, done4, cout4;
    logic [23:0] a4, b4, sum4;
    // WORDS=1 instance
    logic        start1, cin1, ready1, busy1, done1, cout1;
    logic [5:0]  a1, b1, sum1;

    sklansky_seq_add #(.WORDS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4),
        .cin(cin4), .ready(ready4), .busy(busy4), .done(done4),
        .sum_out(sum4), .cout(cout4)
    );

    sklansky_seq_add #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
        .cin(cin1), .ready(ready1), .busy(busy1), .done(done1),
        .sum_out(sum1), .cout(cout1)
    );

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles from accepted start to done: one per word, plus one per word
    // entered with a pending carry.
    function automatic int model_lat(input int words, input logic [95:0] a,
                                     input logic [95:0] b, input logic c);
        logic       carry;
        logic [6:0] t;
        int         n;
        carry = c;
        n     = 0;
        for (int w = 0; w < words; w++) begin
            if (carry) n++;
            t     = {1'b0, a[6*w +: 6]} + {1'b0, b[6*w +: 6]} + {6'd0, carry};
            carry = t[6];
        end
        return words + n;
    endfunction

    task automatic run4(input string tag, input logic [23:0] a,
                        input logic [23:0] b, input logic c,
                        input bit interfere);
        exp_t e;
        int   ndone;
        @(negedge clk);
        check({tag, "_ready"}, 32'(ready4), 32'd1);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        e.val = 32'(a) + 32'(b) + 32'(c);
        e.due = cyc + 1 + model_lat(4, 96'(a), 96'(b), c);
        q4.push_back(e);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (interfere && k == 1) begin
                check({tag, "_busy"}, 32'(busy4), 32'd1);
                a4 = 24'h123456; b4 = 24'h654321; cin4 = 1'b1; start4 = 1'b1;
            end
            if (done4) begin
                ndone++;
                if (q4.size() > 0) begin
                    e = q4.pop_front();
                    check({tag, "_sum"}, {7'd0, cout4, sum4}, e.val);
                    check({tag, "_lat"}, 32'(cyc), 32'(e.due));
                end
            end
        end
        check({tag, "_ndone"}, 32'(ndone), 32'd1);
        q4.delete();
    endtask

    initial begin
        int   ndone;
        int   sent, got, guard;
        exp_t e;
        logic [12:0] op;

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready4), 32'd1);
        check("rst_busy",  32'(busy4),  32'd0);
        check("rst_done",  32'(done4),  32'd0);
        check("rst_sum",   32'(sum4),   32'd0);
        check("rst_cout",  32'(cout4),  32'd0);
        check("rst_ready1", 32'(ready1), 32'd1);
        rst = 1'b0;

        run4("small",   24'h000001, 24'h000002, 1'b0, 1'b0);
        run4("ripple",  24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
        run4("cin0",    24'h000000, 24'h000000, 1'b1, 1'b0);
        run4("allones", 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0);
        run4("mixed",   24'hABCDEF, 24'h13579B, 1'b0, 1'b0);
        run4("ignore",  24'hFFFFFF, 24'h000001, 1'b0, 1'b1);

        // Reset two edges into an operation aborts it.
        @(negedge clk);
        a4 = 24'hFFFFFF; b4 = 24'h000001; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready4), 32'd1);
        check("abort_busy",  32'(busy4),  32'd0);
        check("abort_done",  32'(done4),  32'd0);
        check("abort_sum",   32'(sum4),   32'd0);
        check("abort_cout",  32'(cout4),  32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        check("abort_nodone", 32'(ndone), 32'd0);

        // Exhaustive WORDS=1 sweep, starts issued in the first IDLE cycle.
        sent = 0; got = 0; guard = 0;
        while (got < 8192 && guard < 60000) begin
            @(negedge clk);
            guard++;
            start1 = 1'b0;
            if (done1) begin
                if (q1.size() == 0) begin
                    check("exh_spurious_done", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("exh_sum", {25'd0, cout1, sum1}, e.val);
                    check("exh_lat", 32'(cyc), 32'(e.due));
                end
                got++;
            end
            if (ready1 && sent < 8192) begin
                op = 13'(sent);
                a1 = op[5:0]; b1 = op[11:6]; cin1 = op[12];
                start1 = 1'b1;
                e.val = 32'(op[5:0]) + 32'(op[11:6]) + 32'(op[12]);
                e.due = cyc + 1 + model_lat(1, 96'(op[5:0]), 96'(op[11:6]), op[12]);
                q1.push_back(e);
                sent++;
            end
        end
        if (got < 8192) check("exh_timeout", 32'(got), 32'd8192);
        $display("exhaustive WORDS=1 operations completed: %0d", got);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
